// File: rtl/fnd_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_driver_if
//  Description : Data/display bundle between the counter datapath and the
//                multiplexed 7-segment scan driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fnd_scan_driver_if #(
    parameter int DIGITS = 4
) ();
    localparam int IDX_W = $clog2(DIGITS);

    logic                  i_en;
    logic [DIGITS*4-1:0]   i_data;
    logic [DIGITS-1:0]     i_dp;
    logic                  i_blank_lz;
    logic [DIGITS-1:0]     o_digit_sel;
    logic [7:0]            o_seg;
    logic [IDX_W-1:0]      o_scan_idx;
    logic                  o_frame_tick;

    modport master (
        output i_en, i_data, i_dp, i_blank_lz,
        input  o_digit_sel, o_seg, o_scan_idx, o_frame_tick
    );

    modport slave (
        input  i_en, i_data, i_dp, i_blank_lz,
        output o_digit_sel, o_seg, o_scan_idx, o_frame_tick
    );
endinterface
`default_nettype wire

// File: rtl/fnd_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_driver
//  Description : N-digit time-multiplexed 7-segment driver with hex decode,
//                decimal points, leading-zero blanking and a frame tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module fnd_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000,
    parameter int IDX_W    = $clog2(DIGITS)
) (
    input  wire logic           i_clk,
    input  wire logic           i_reset,
    fnd_scan_driver_if.slave    bus
);
    localparam int                 c_PRE_W   = $clog2(SCAN_DIV);
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   c_IDX_MAX = IDX_W'(DIGITS - 1);

    logic [c_PRE_W-1:0] r_pre;
    logic [IDX_W-1:0]   r_idx;
    logic               r_tick;
    logic [DIGITS-1:0]  r_sel;
    logic [7:0]         r_seg;

    logic               w_tc;
    logic [3:0]         w_nib;
    logic               w_dp;
    logic               w_blank;
    logic               w_zero_run;
    logic [DIGITS-1:0]  w_lz;
    logic [7:0]         w_seg;

    // Active-low {g,f,e,d,c,b,a}; bit 7 (dp) is supplied separately.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign w_tc = (r_pre == c_PRE_MAX);

    always_comb begin
        w_nib      = 4'h0;
        w_dp       = 1'b0;
        w_blank    = 1'b0;
        w_zero_run = 1'b1;
        w_lz       = '0;
        // w_lz[k] marks that nibbles k..MSD are all zero
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run & (bus.i_data[4*k +: 4] == 4'h0);
            w_lz[k]    = w_zero_run;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib   = bus.i_data[4*k +: 4];
                w_dp    = bus.i_dp[k];
                w_blank = bus.i_blank_lz && (k > 0) && w_lz[k];
            end
        end
        w_seg = {~w_dp, (w_blank ? 7'h7F : hex_to_seg(w_nib))};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pre  <= '0;
            r_idx  <= '0;
            r_tick <= 1'b0;
            r_sel  <= '1;
            r_seg  <= 8'hFF;
        end else if (bus.i_en) begin
            r_pre  <= w_tc ? '0 : r_pre + c_PRE_W'(1);
            if (w_tc) begin
                r_idx <= (r_idx == c_IDX_MAX) ? '0 : r_idx + IDX_W'(1);
            end
            r_tick <= w_tc && (r_idx == c_IDX_MAX);
            // Outputs reflect the index held before this edge: one-cycle lag
            r_sel  <= ~(DIGITS'(1) << r_idx);
            r_seg  <= w_seg;
        end else begin
            r_tick <= 1'b0;
            r_sel  <= '1;
            r_seg  <= 8'hFF;
        end
    end

    assign bus.o_digit_sel  = r_sel;
    assign bus.o_seg        = r_seg;
    assign bus.o_scan_idx   = r_idx;
    assign bus.o_frame_tick = r_tick;

endmodule
`default_nettype wire
